// File: rtl/sass_seq_ctrl.sv
// SaSS step sequencer: priority-encodes the piano keys, records a NUM_STEPS note
// pattern and plays it back at one of two tempos, driving note code and panel LEDs.
module sass_seq_ctrl #(
  parameter int NUM_STEPS  = 8,
  parameter int SLOW_TICKS = 5000000,
  parameter int FAST_TICKS = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [14:0]          piano_keys,
  input  logic                 seq_power,
  input  logic                 tempo_select,
  input  logic                 seq_play,
  output logic [3:0]           note_out,
  output logic                 note_valid,
  output logic [1:0]           mode_out,
  output logic [NUM_STEPS-1:0] beat_led,
  output logic                 seq_led_on,
  output logic                 tempo_fast
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0]     SLOW_LAST = CNT_W'(SLOW_TICKS - 1);
  localparam logic [CNT_W-1:0]     FAST_LAST = CNT_W'(FAST_TICKS - 1);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [NUM_STEPS-1:0] BEAT_ONE  = NUM_STEPS'(1);

  // State encoding doubles as the mode_out code.
  typedef enum logic [1:0] {OFF = 2'b00, RECORD = 2'b01, PLAY = 2'b10} state_t;

  state_t            state_reg;
  logic [STEP_W-1:0] step_reg;
  logic [CNT_W-1:0]  tick_reg;
  logic [3:0]        mem [NUM_STEPS];
  logic [3:0]        code_prev_reg;
  logic              tempo_prev_reg;
  logic              play_prev_reg;

  logic [3:0]        code;
  logic [3:0]        note_next;
  logic              key_evt;
  logic              play_evt;
  logic              tempo_evt;
  logic              tick_done;
  logic [STEP_W-1:0] step_next;

  // Lowest-numbered pressed key wins.
  always_comb begin
    code = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (piano_keys[i]) code = 4'(i + 1);
    end
  end

  assign key_evt   = (code_prev_reg == 4'd0) && (code != 4'd0);
  assign play_evt  = seq_play && !play_prev_reg;
  assign tempo_evt = tempo_select && !tempo_prev_reg;
  assign tick_done = tick_reg >= (tempo_fast ? FAST_LAST : SLOW_LAST);
  assign step_next = (step_reg == STEP_LAST) ? '0 : step_reg + STEP_W'(1);

  // A live key always overrides the stored pattern during playback.
  always_comb begin
    note_next = code;
    if ((state_reg == PLAY) && (code == 4'd0)) note_next = mem[step_reg];
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg      <= OFF;
      step_reg       <= '0;
      tick_reg       <= '0;
      tempo_fast     <= 1'b0;
      code_prev_reg  <= 4'd0;
      tempo_prev_reg <= 1'b1;
      play_prev_reg  <= 1'b1;
      note_out       <= 4'd0;
      note_valid     <= 1'b0;
      mode_out       <= 2'b00;
      beat_led       <= '0;
      seq_led_on     <= 1'b0;
      for (int i = 0; i < NUM_STEPS; i++) mem[i] <= 4'd0;
    end else begin
      code_prev_reg  <= code;
      tempo_prev_reg <= tempo_select;
      play_prev_reg  <= seq_play;

      note_out   <= note_next;
      note_valid <= (note_next != 4'd0);
      mode_out   <= state_reg;
      beat_led   <= (state_reg == OFF) ? '0 : (BEAT_ONE << step_reg);
      seq_led_on <= (state_reg != OFF);

      // In RECORD the tempo button means "rest", so it only retimes OFF and PLAY.
      if (tempo_evt && ((state_reg == OFF) || ((state_reg == PLAY) && seq_power)))
        tempo_fast <= !tempo_fast;

      if (!seq_power) begin
        state_reg <= OFF;
        tick_reg  <= '0;
      end else begin
        case (state_reg)
          OFF: begin
            state_reg <= RECORD;
            step_reg  <= '0;
          end
          RECORD: begin
            if (play_evt) begin
              state_reg <= PLAY;
              step_reg  <= '0;
              tick_reg  <= '0;
            end else if (key_evt || tempo_evt) begin
              mem[step_reg] <= key_evt ? code : 4'd0;
              step_reg      <= step_next;
            end
          end
          PLAY: begin
            if (play_evt) begin
              state_reg <= RECORD;
              step_reg  <= '0;
              tick_reg  <= '0;
            end else if (tick_done) begin
              tick_reg <= '0;
              step_reg <= step_next;
            end else begin
              tick_reg <= tick_reg + CNT_W'(1);
            end
          end
          default: state_reg <= OFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sass_seq_ctrl.sv
// Randomized self-checking bench for sass_seq_ctrl; expectations come from a pattern
// array plus step = elapsed_cycles / ticks_per_step arithmetic.
module tb_sass_seq_ctrl;
  localparam int N    = 8;
  localparam int SLOW = 8;
  localparam int FAST = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [14:0]  piano_keys = '0;
  logic         seq_power = 1'b0;
  logic         tempo_select = 1'b0;
  logic         seq_play = 1'b0;
  logic [3:0]   note_out;
  logic         note_valid;
  logic [1:0]   mode_out;
  logic [N-1:0] beat_led;
  logic         seq_led_on;
  logic         tempo_fast;

  int n_checks = 0;
  int n_errors = 0;
  int exp_mem [N];

  sass_seq_ctrl #(.NUM_STEPS(N), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST), .CNT_W(24)) dut (
    .clk(clk), .n_rst(n_rst), .piano_keys(piano_keys), .seq_power(seq_power),
    .tempo_select(tempo_select), .seq_play(seq_play), .note_out(note_out),
    .note_valid(note_valid), .mode_out(mode_out), .beat_led(beat_led),
    .seq_led_on(seq_led_on), .tempo_fast(tempo_fast)
  );

  always #5 clk = ~clk;

  function automatic int key_code(input logic [14:0] m);
    for (int i = 0; i < 15; i++) if (m[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  function automatic logic [14:0] rand_mask();
    logic [14:0] m;
    m = 15'($urandom) & 15'($urandom);
    if (m == 15'd0) m = 15'h4000;
    return m;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_play();
    seq_play = 1'b1;
    step_clk();
    seq_play = 1'b0;
  endtask

  task automatic pulse_tempo();
    tempo_select = 1'b1;
    step_clk();
    tempo_select = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; seq_power = 1'b0; piano_keys = '0; seq_play = 1'b1; tempo_select = 1'b1;
    repeat (3) step_clk();
    n_checks++; if (note_out !== 4'd0) begin n_errors++; $display("FAIL rst_note: got %0d want 0", note_out); end
    n_checks++; if (note_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %0b want 0", note_valid); end
    n_checks++; if (mode_out !== 2'b00) begin n_errors++; $display("FAIL rst_mode: got %b want 00", mode_out); end
    n_checks++; if (beat_led !== '0) begin n_errors++; $display("FAIL rst_beat: got %h want 0", beat_led); end
    n_checks++; if (seq_led_on !== 1'b0) begin n_errors++; $display("FAIL rst_seqled: got %0b want 0", seq_led_on); end
    // Buttons held through reset must not register as edges.
    n_rst = 1'b1;
    repeat (2) step_clk();
    n_checks++; if (tempo_fast !== 1'b0) begin n_errors++; $display("FAIL rst_held_tempo: got %0b want 0", tempo_fast); end
    n_checks++; if (mode_out !== 2'b00) begin n_errors++; $display("FAIL rst_held_mode: got %b want 00", mode_out); end
    seq_play = 1'b0; tempo_select = 1'b0;
    step_clk();
    $display("reset: outputs idle, tempo_fast=%0b", tempo_fast);
  endtask

  task automatic test_off_passthrough();
    logic [14:0] m;
    int want;
    for (int t = 0; t < 10; t++) begin
      m = (t == 0) ? 15'h0004 : (t == 1) ? 15'h0000 : (t == 2) ? 15'h4000 : 15'($urandom);
      want = key_code(m);
      piano_keys = m;
      step_clk();
      n_checks++; if (note_out !== 4'(want)) begin n_errors++; $display("FAIL off_note: keys=%h got %0d want %0d", m, note_out, want); end
      n_checks++; if (note_valid !== (want != 0)) begin n_errors++; $display("FAIL off_valid: got %0b want %0b", note_valid, want != 0); end
      n_checks++; if (mode_out !== 2'b00 || beat_led !== '0) begin n_errors++; $display("FAIL off_leds: mode=%b beat=%h want 00/0", mode_out, beat_led); end
      $display("off: keys=%h note=%0d", m, note_out);
    end
    piano_keys = '0;
    step_clk();
    pulse_tempo();
    n_checks++; if (tempo_fast !== 1'b1) begin n_errors++; $display("FAIL off_tempo_on: got %0b want 1", tempo_fast); end
    step_clk();
    pulse_tempo();
    n_checks++; if (tempo_fast !== 1'b0) begin n_errors++; $display("FAIL off_tempo_off: got %0b want 0", tempo_fast); end
    step_clk();
  endtask

  task automatic test_record(input bit use_random);
    logic [14:0] m;
    if (use_random) pulse_play();
    else begin seq_power = 1'b1; step_clk(); end
    step_clk();
    n_checks++; if (mode_out !== 2'b01) begin n_errors++; $display("FAIL rec_mode: got %b want 01", mode_out); end
    n_checks++; if (beat_led !== onehot(0)) begin n_errors++; $display("FAIL rec_beat0: got %h want %h", beat_led, onehot(0)); end
    n_checks++; if (seq_led_on !== 1'b1) begin n_errors++; $display("FAIL rec_seqled: got %0b want 1", seq_led_on); end
    for (int i = 0; i < N; i++) begin
      if (use_random) m = ($urandom_range(3) == 0) ? 15'h0 : rand_mask();
      else m = (i == 3) ? 15'h0 : 15'(1 << i);
      exp_mem[i] = key_code(m);
      if (m == 15'h0) tempo_select = 1'b1;
      else piano_keys = m;
      step_clk();
      n_checks++; if (note_out !== 4'(exp_mem[i])) begin n_errors++; $display("FAIL rec_live: step %0d got %0d want %0d", i, note_out, exp_mem[i]); end
      piano_keys = '0; tempo_select = 1'b0;
      step_clk();
      n_checks++; if (beat_led !== onehot((i + 1) % N)) begin n_errors++; $display("FAIL rec_beat: step %0d got %h want %h", i, beat_led, onehot((i + 1) % N)); end
      n_checks++; if (tempo_fast !== 1'b0) begin n_errors++; $display("FAIL rec_tempo: got %0b want 0", tempo_fast); end
      $display("record: step %0d keys=%h stored %0d", i, m, exp_mem[i]);
    end
  endtask

  task automatic test_playback();
    int s;
    pulse_play();
    for (int n = 1; n <= 2 * N * SLOW + 1; n++) begin
      step_clk();
      s = ((n - 1) / SLOW) % N;
      n_checks++; if (note_out !== 4'(exp_mem[s]) || note_valid !== (exp_mem[s] != 0)) begin n_errors++; $display("FAIL play_note: cyc %0d got %0d/%0b want %0d", n, note_out, note_valid, exp_mem[s]); end
      n_checks++; if (beat_led !== onehot(s) || mode_out !== 2'b10) begin n_errors++; $display("FAIL play_beat: cyc %0d got %h/%b want %h/10", n, beat_led, mode_out, onehot(s)); end
    end
    $display("playback: %0d cycles walked at slow tempo", 2 * N * SLOW + 1);
  endtask

  task automatic test_tempo_switch();
    int s;
    pulse_play();
    step_clk();
    pulse_play();
    for (int n = 1; n <= 8 + 4 * 10; n++) begin
      if (n == 7) tempo_select = 1'b1;
      step_clk();
      tempo_select = 1'b0;
      s = (n < 9) ? 0 : (1 + (n - 9) / FAST) % N;
      n_checks++; if (tempo_fast !== (n >= 7)) begin n_errors++; $display("FAIL tempo_flag: cyc %0d got %0b want %0b", n, tempo_fast, n >= 7); end
      n_checks++; if (note_out !== 4'(exp_mem[s]) || beat_led !== onehot(s)) begin n_errors++; $display("FAIL tempo_step: cyc %0d got %0d/%h want %0d/%h", n, note_out, beat_led, exp_mem[s], onehot(s)); end
    end
    pulse_tempo();
    n_checks++; if (tempo_fast !== 1'b0) begin n_errors++; $display("FAIL tempo_back: got %0b want 0", tempo_fast); end
    $display("tempo: switched to fast mid-step and back to slow");
  endtask

  task automatic test_collision();
    int k;
    int s;
    pulse_play();
    step_clk();
    k = (exp_mem[0] >= 15) ? 0 : exp_mem[0];
    piano_keys = 15'(1 << k);
    seq_play = 1'b1;
    step_clk();
    piano_keys = '0; seq_play = 1'b0;
    for (int n = 1; n <= N * SLOW + 1; n++) begin
      step_clk();
      s = ((n - 1) / SLOW) % N;
      n_checks++; if (mode_out !== 2'b10) begin n_errors++; $display("FAIL coll_mode: cyc %0d got %b want 10", n, mode_out); end
      n_checks++; if (note_out !== 4'(exp_mem[s]) || beat_led !== onehot(s)) begin n_errors++; $display("FAIL coll_note: cyc %0d got %0d/%h want %0d/%h", n, note_out, beat_led, exp_mem[s], onehot(s)); end
    end
    $display("collision: key %0d with play edge, pattern intact", k);
  endtask

  task automatic test_random_pattern();
    logic [14:0] m;
    int s;
    int want;
    test_record(1'b1);
    pulse_play();
    for (int n = 1; n <= 2 * N * SLOW; n++) begin
      m = ($urandom_range(5) == 0) ? rand_mask() : 15'h0;
      piano_keys = m;
      step_clk();
      s = ((n - 1) / SLOW) % N;
      want = (key_code(m) != 0) ? key_code(m) : exp_mem[s];
      n_checks++; if (note_out !== 4'(want) || note_valid !== (want != 0)) begin n_errors++; $display("FAIL rand_note: cyc %0d keys=%h got %0d want %0d", n, m, note_out, want); end
      n_checks++; if (beat_led !== onehot(s)) begin n_errors++; $display("FAIL rand_beat: cyc %0d got %h want %h", n, beat_led, onehot(s)); end
    end
    piano_keys = '0;
    $display("random: pattern %0d %0d %0d %0d %0d %0d %0d %0d played with live keys",
             exp_mem[0], exp_mem[1], exp_mem[2], exp_mem[3], exp_mem[4], exp_mem[5], exp_mem[6], exp_mem[7]);
  endtask

  task automatic test_power_drop();
    int s;
    seq_power = 1'b0;
    repeat (2) step_clk();
    n_checks++; if (mode_out !== 2'b00 || beat_led !== '0 || seq_led_on !== 1'b0) begin n_errors++; $display("FAIL pwr_off: mode=%b beat=%h led=%0b want 00/0/0", mode_out, beat_led, seq_led_on); end
    seq_power = 1'b1;
    repeat (2) step_clk();
    n_checks++; if (mode_out !== 2'b01 || beat_led !== onehot(0)) begin n_errors++; $display("FAIL pwr_on: mode=%b beat=%h want 01/%h", mode_out, beat_led, onehot(0)); end
    pulse_play();
    for (int n = 1; n <= N * SLOW + 1; n++) begin
      step_clk();
      s = ((n - 1) / SLOW) % N;
      n_checks++; if (note_out !== 4'(exp_mem[s])) begin n_errors++; $display("FAIL pwr_keep: cyc %0d got %0d want %0d", n, note_out, exp_mem[s]); end
    end
    n_rst = 1'b0;
    step_clk();
    n_rst = 1'b1;
    n_checks++; if (note_out !== 4'd0 || mode_out !== 2'b00 || beat_led !== '0 || seq_led_on !== 1'b0 || tempo_fast !== 1'b0) begin n_errors++; $display("FAIL mid_rst: note=%0d mode=%b beat=%h want all 0", note_out, mode_out, beat_led); end
    for (int i = 0; i < N; i++) exp_mem[i] = 0;
    repeat (2) step_clk();
    pulse_play();
    for (int n = 1; n <= N * SLOW; n++) begin
      step_clk();
      n_checks++; if (note_out !== 4'd0 || note_valid !== 1'b0 || mode_out !== 2'b10) begin n_errors++; $display("FAIL rst_clear: cyc %0d got %0d/%0b/%b want 0/0/10", n, note_out, note_valid, mode_out); end
    end
    $display("power: drop/restore kept pattern, reset cleared it");
  endtask

  initial begin
    test_reset();
    test_off_passthrough();
    test_record(1'b0);
    test_playback();
    test_tempo_switch();
    test_collision();
    test_random_pattern();
    test_power_drop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sass_seq_ctrl.md
Name: sass_seq_ctrl

Overview:
Step-sequencer controller for the SaSS synth. It priority-encodes the piano keys and records an NUM_STEPS-step note pattern. It plays the pattern back at one of two tempos and drives the note code consumed by the oscillator/PWM datapath, plus the mode, beat and sequencer LED outputs. It sits between the debounced/synchronized button inputs and the oscillator inside sass_synth.

Parameters:
NUM_STEPS, 8, pattern length; also width of beat_led
SLOW_TICKS, 5000000, clk cycles per step at slow tempo
FAST_TICKS, 2500000, clk cycles per step at fast tempo (< SLOW_TICKS)
CNT_W, 24, tick counter width; must hold SLOW_TICKS-1

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
piano_keys  in  15  key levels, already synchronized/debounced
seq_power  in  1  level; 1 = sequencer enabled
tempo_select  in  1  button level; rising edge used
seq_play  in  1  button level; rising edge used
note_out  out  4  note code to oscillator; 0 = rest, k = key index k-1
note_valid  out  1  note_out != 0
mode_out  out  2  00 OFF, 01 RECORD, 10 PLAY (11 unused)
beat_led  out  NUM_STEPS  one-hot current step
seq_led_on  out  1  1 in RECORD or PLAY
tempo_fast  out  1  1 = FAST_TICKS active

Behaviour:
- Reset (n_rst=0 at clk edge):
  - State OFF; step pointer 0; tick counter 0; tempo_fast 0.
  - All pattern entries 0; all outputs 0.
  - Edge-detect history for tempo_select and seq_play set to 1, so a button held through reset gives no edge. Key-code history is set to 0.
- Key encode (combinational):
  - code = (lowest set bit index in piano_keys) + 1.
  - code = 0 if no key is pressed.
- Events:
  - key_evt: previous code == 0 and current code != 0.
  - play_evt: seq_play rising edge.
  - tempo_evt: tempo_select rising edge.
- State transitions, checked in this priority order:
  1. seq_power=0 → OFF from any state.
  2. OFF with seq_power=1 → RECORD, step=0.
  3. RECORD with play_evt → PLAY, step=0, tick=0.
  4. PLAY with play_evt → RECORD, step=0.
- OFF:
  - note_out = code (live passthrough).
  - beat_led=0, seq_led_on=0, mode_out=00.
  - Pattern memory is retained. Only reset clears it.
- RECORD:
  - note_out = live code; beat_led = one-hot(step); seq_led_on=1; mode_out=01.
  - key_evt: mem[step] ← code, step ← step+1.
  - tempo_evt without key_evt: mem[step] ← 0 (rest), step ← step+1.
  - key_evt and tempo_evt in the same cycle: one write of code, one advance.
  - play_evt in the same cycle as key_evt or tempo_evt: the transition wins. No write, no advance.
  - step wraps NUM_STEPS-1 → 0.
- PLAY:
  - note_out = code if code != 0 (live override), else mem[step].
  - beat_led = one-hot(step); seq_led_on=1; mode_out=10.
  - tick increments each cycle. When tick ≥ limit-1 (limit = FAST_TICKS if tempo_fast, else SLOW_TICKS): tick ← 0, step ← step+1 with wrap.
  - tempo_evt toggles tempo_fast immediately. If tick already ≥ new limit-1, the step advances on the next cycle. Never stall, never skip two steps in one cycle.
  - Key events do not write memory.
- tempo_evt outside PLAY:
  - In RECORD it enters a rest and does not toggle tempo.
  - In OFF it toggles tempo_fast.
- Timing: all outputs are registered. Latency is 1 clk from input/state change to output. note_valid is registered consistently with note_out.
- Reset mid-operation: returns to OFF and clears memory on the same edge.

Test Plan:
1. Overrides SLOW_TICKS=8, FAST_TICKS=4. Reset with seq_power=0, then press piano_keys=15'h0004 → note_out=3, note_valid=1, mode_out=00, beat_led=0 one cycle later.
2. seq_power=1. Press keys 0,1,2 as separate presses, then tempo_select pulse, then keys 4,5,6,7 → mem = {1,2,3,0,5,6,7,8}, step wraps to 0, beat_led=8'h01, mode_out=01.
3. From test 2, pulse seq_play → mode_out=10. note_out sequence is 1,2,3,0,5,6,7,8,1,… with each value held 8 cycles. beat_led walks 01→02→…→80→01.
4. In PLAY at tick=6 of a slow step, pulse tempo_select → tempo_fast=1, step advances next cycle, then every 4 cycles.
5. In RECORD, key press and seq_play edge in the same cycle → mode_out=10, that key not stored, playback starts at step 0.
6. In PLAY, drop seq_power → mode_out=00, beat_led=0. Re-raise seq_power, then play → stored pattern unchanged. Assert n_rst=0 for 1 cycle → pattern all zeros, outputs 0.
